mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives the MEM/WB register.

---
 rtl/mem_stage_lsu.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues aligned data-memory accesses and formats load data for MEM/WB.
// Latency: MEM/WB updates on the edge where dmem_ready completes the access; non-memory ops take 1 cycle.
// Backpressure: holds the upstream pipe via stall_req while memory is not ready; aborts after TIMEOUT_CYCLES.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [2:0]  ex_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_req,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t        state;
  logic [CW-1:0] count;

  logic        mem_op;
  logic        is_store;
  logic        f3_ok;
  logic        addr_bad;
  logic        bad_access;
  logic        legal_op;
  logic        complete;
  logic [1:0]  lane;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // A store wins when both read and write are set.
  assign mem_op   = ex_mem_read | ex_mem_write;
  assign is_store = ex_mem_write;
  assign lane     = ex_alu_result[1:0];

  // Legal funct3 encodings differ for loads and stores.
  always_comb begin
    f3_ok = 1'b0;
    if (is_store) begin
      f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    end else begin
      f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
              (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    end
  end

  assign addr_bad   = ((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
                      ((ex_funct3[1:0] == 2'b10) & (|ex_alu_result[1:0]));
  assign bad_access = mem_op & (~f3_ok | addr_bad);
  assign legal_op   = mem_op & ~bad_access;

  // Reset gates the request path so it drops without waiting for an edge.
  assign dmem_req  = ~reset & legal_op & (state != ERR);
  assign stall_req = dmem_req & ~dmem_ready;
  assign complete  = dmem_req & dmem_ready;

  // Replicate store data across lanes and build the byte enables.
  always_comb begin
    st_wdata = ex_write_data;
    st_wstrb = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_write_data[7:0]}};
        st_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        st_wdata = {2{ex_write_data[15:0]}};
        st_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
      end
      default: begin
        st_wdata = ex_write_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = dmem_req ? {ex_alu_result[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = dmem_we ? st_wdata : 32'h0;
  assign dmem_wstrb = dmem_we ? st_wstrb : 4'h0;

  // Pick the addressed byte/half from the read word and extend it.
  always_comb begin
    byte_sel  = dmem_rdata[{lane, 3'b000} +: 8];
    half_sel  = dmem_rdata[{ex_alu_result[1], 4'b0000} +: 16];
    load_data = dmem_rdata;
    case (ex_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // Access FSM: wait for ready, give up after TIMEOUT_CYCLES request cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (legal_op && !dmem_ready) begin
            state <= WAIT;
            count <= CW'(1);
          end
        end
        WAIT: begin
          if (!legal_op || dmem_ready) begin
            state <= IDLE;
            count <= '0;
          end else if (count == LAST) begin
            state <= ERR;
          end else begin
            count <= count + 1'b1;
          end
        end
        ERR: begin
          state <= IDLE;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble on stall, abort or bad access; otherwise capture the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_alu_result <= 32'h0;
      wb_load_data  <= 32'h0;
      wb_rd         <= 5'h0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      misaligned    <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      wb_alu_result <= 32'h0;
      wb_load_data  <= 32'h0;
      wb_rd         <= 5'h0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      misaligned    <= 1'b0;
      bus_err       <= 1'b0;
      if (state == ERR) begin
        bus_err <= 1'b1;
      end else if (bad_access) begin
        misaligned <= 1'b1;
      end else if (!stall_req) begin
        wb_alu_result <= ex_alu_result;
        wb_load_data  <= (complete && !is_store) ? load_data : 32'h0;
        wb_rd         <= ex_rd;
        wb_reg_write  <= ex_reg_write;
        wb_mem_to_reg <= ex_mem_to_reg;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases then random instructions against a transaction model.
// Inputs change 1 time unit after the rising edge; combinational outputs are sampled on the falling edge.
// MEM/WB outputs are sampled 1 time unit after the rising edge that loads them.
module tb_mem_stage_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [2:0]  ex_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_req;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_load_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        misaligned;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_funct3(ex_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_req(stall_req),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic [31:0] alu, input logic chk_ld,
                          input logic [31:0] ld, input logic [4:0] rd, input logic rw,
                          input logic m2r, input logic mis, input logic berr);
    chk({tag, ".wb_alu"}, wb_alu_result, alu);
    if (chk_ld) chk({tag, ".wb_load"}, wb_load_data, ld);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, ".wb_rw"}, 32'(wb_reg_write), 32'(rw));
    chk({tag, ".wb_m2r"}, 32'(wb_mem_to_reg), 32'(m2r));
    chk({tag, ".misal"}, 32'(misaligned), 32'(mis));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(berr));
  endtask

  task automatic check_idle_bus(input string tag);
    chk({tag, ".req"}, 32'(dmem_req), 32'd0);
    chk({tag, ".stall"}, 32'(stall_req), 32'd0);
    chk({tag, ".we"}, 32'(dmem_we), 32'd0);
    chk({tag, ".addr"}, dmem_addr, 32'd0);
    chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'd0);
  endtask

  task automatic clear_inputs();
    ex_alu_result = 32'h0; ex_write_data = 32'h0; ex_rd = 5'h0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_mem_to_reg = 1'b0; ex_funct3 = 3'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
  endtask

  // One instruction from EX/MEM to MEM/WB; lat = cycles memory holds ready low.
  // Starts and ends 1 time unit after a rising edge.
  task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic ld, input logic st, input logic rw,
                        input logic m2r, input logic [2:0] f3, input logic [31:0] rdata,
                        input int lat);
    int unsigned size;
    int unsigned off;
    bit          memop;
    bit          f3_ok;
    bit          bad;
    bit          done;
    logic [31:0] mask;
    logic [31:0] val;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;

    memop = ld || st;
    size  = 1 << f3[1:0];
    off   = addr % 4;
    if (st) f3_ok = (f3 <= 3'd2);
    else    f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    bad   = memop && (!f3_ok || (addr % size) != 0);

    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (size == 1)      exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
    else if (size == 2) exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    else                exp_wdata = wd;
    exp_wstrb = 4'(((1 << size) - 1) << off);
    val = (rdata >> (8 * off)) & mask;
    if (f3 < 3'd4 && size < 4 && ((val >> (8 * size - 1)) & 32'd1) == 32'd1) val = val | ~mask;

    ex_alu_result = addr; ex_write_data = wd; ex_rd = rd;
    ex_mem_read = ld; ex_mem_write = st; ex_reg_write = rw;
    ex_mem_to_reg = m2r; ex_funct3 = f3;

    if (!memop || bad) begin
      dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = rdata;
      @(negedge clk);
      check_idle_bus({tag, ".nr"});
      @(posedge clk); #1;
      if (bad) check_wb({tag, ".bad"}, 32'h0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      else     check_wb({tag, ".pass"}, addr, 1'b1, 32'h0, rd, rw, m2r, 1'b0, 1'b0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < T && !done; k++) begin
        dmem_ready = (k == lat);
        dmem_rdata = (k == lat) ? rdata : $urandom;
        @(negedge clk);
        chk({tag, ".req"}, 32'(dmem_req), 32'd1);
        chk({tag, ".stall"}, 32'(stall_req), 32'(k != lat));
        chk({tag, ".we"}, 32'(dmem_we), 32'(st));
        chk({tag, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".wstrb"}, 32'(dmem_wstrb), st ? 32'(exp_wstrb) : 32'd0);
        if (st) chk({tag, ".wdata"}, dmem_wdata, exp_wdata);
        @(posedge clk); #1;
        if (k == lat) begin
          done = 1'b1;
          check_wb({tag, ".done"}, addr, !st, val, rd, rw, m2r, 1'b0, 1'b0);
        end else begin
          check_wb({tag, ".wait"}, 32'h0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
      end
      if (!done) begin
        dmem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_idle_bus({tag, ".err"});
        @(posedge clk); #1;
        check_wb({tag, ".abort"}, 32'h0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: a legal load presented during reset must not raise a request.
    reset = 1'b1;
    clear_inputs();
    ex_alu_result = 32'h100; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_funct3 = 3'b010;
    #2;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(stall_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_wb("rst", 32'h0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op("t1_lw", 32'h100, 32'h0, 5'd3, 1, 0, 1, 1, 3'b010, 32'hDEAD_BEEF, 0);
    chk("t1.load", wb_load_data, 32'hDEAD_BEEF);
    chk("t1.rw", 32'(wb_reg_write), 32'd1);
    run_op("t2_lb", 32'h103, 32'h0, 5'd4, 1, 0, 1, 1, 3'b000, 32'h8012_3456, 1);
    chk("t2.lb", wb_load_data, 32'hFFFF_FF80);
    run_op("t2_lbu", 32'h103, 32'h0, 5'd4, 1, 0, 1, 1, 3'b100, 32'h8012_3456, 0);
    chk("t2.lbu", wb_load_data, 32'h0000_0080);
    run_op("t3_sh", 32'h102, 32'h1234_ABCD, 5'd0, 0, 1, 0, 0, 3'b001, 32'h0, 3);
    run_op("t4_lw", 32'h101, 32'h0, 5'd5, 1, 0, 1, 1, 3'b010, 32'h0, 0);
    chk("t4.misal", 32'(misaligned), 32'd1);
    run_op("t5_to", 32'h200, 32'h0, 5'd6, 1, 0, 1, 1, 3'b010, 32'h0, 10);
    chk("t5.bus_err", 32'(bus_err), 32'd1);
    run_op("t5_after", 32'h0, 32'h0, 5'd7, 0, 0, 1, 0, 3'b000, 32'h0, 0);
    run_op("sb_lane2", 32'h12, 32'h0000_00A5, 5'd0, 0, 1, 0, 0, 3'b000, 32'h0, 0);
    run_op("both_st", 32'h20, 32'hCAFE_F00D, 5'd8, 1, 1, 0, 0, 3'b010, 32'h0, 1);
    run_op("ill_st", 32'h30, 32'h0, 5'd9, 0, 1, 0, 0, 3'b100, 32'h0, 0);
    run_op("ill_ld", 32'h30, 32'h0, 5'd9, 1, 0, 1, 1, 3'b011, 32'h0, 0);

    // Reset while waiting on memory: request and stall drop at once, no error pulse.
    ex_alu_result = 32'h300; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    ex_mem_to_reg = 1'b1; ex_funct3 = 3'b010; ex_rd = 5'd11; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6.pre_stall", 32'(stall_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6.req", 32'(dmem_req), 32'd0);
    chk("t6.stall", 32'(stall_req), 32'd0);
    check_wb("t6", 32'h0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t6.no_err", 32'(bus_err), 32'd0);

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic ld_r;
      logic st_r;
      kind = $urandom_range(0, 3);
      ld_r = (kind == 1) || (kind == 3);
      st_r = (kind >= 2);
      run_op("rnd", $urandom, $urandom, 5'($urandom), ld_r, st_r, 1'($urandom),
             1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, T + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
